sensor_link_host: RTL and testbench
===================================

Name: sensor_link_host

Overview:
- Host-side counterpart of the temperature-sensor UART link, used in FPGA test rigs and the system bench.
- Serialises a one-byte command onto the sensor's rx pin, then receives the 3-byte averaged-count response from the sensor's tx pin.
- Reassembles the 24-bit average and flags timeout and framing errors.
- Contains its own 8N1 bit-level transmitter and receiver.

Parameters:
- CLK_FREQ, 10000: clk1 frequency in Hz.
- BAUD, 1000: bit rate. DIV = CLK_FREQ/BAUD clocks per bit; DIV must be ≥ 4.
- TIMEOUT, 400: clk1 cycles allowed with no start bit, counted after the command stop bit ends and after each received stop bit.

Ports:
- clk1, in, 1: clock.
- rst_n, in, 1: reset.
- start, in, 1: one-cycle request to send cmd and collect a response.
- cmd, in, 8: command byte, captured on the cycle start is accepted.
- rx, in, 1: serial input, driven from the sensor's tx; asynchronous.
- tx, out, 1: serial output, driving the sensor's rx; idles high.
- busy, out, 1: high from start acceptance until done/error.
- result, out, 24: last complete reassembled average.
- result_valid, out, 1: one-cycle pulse when result updates.
- timeout_err, out, 1: one-cycle pulse on response timeout.
- framing_err, out, 1: one-cycle pulse on bad stop bit.

Behaviour:
- Reset is rst_n, synchronous, active-low, clocked by clk1. Values while rst_n=0:
  - tx=1, busy=0, result=0, result_valid=0, timeout_err=0, framing_err=0.
  - FSM in IDLE; bit/baud/timeout counters cleared; rx synchroniser flops set to 1.
- rx path: 2-flop synchroniser. All rx decisions use the synchronised signal (2-cycle latency).
- Frame format: 8N1, LSB first. Start bit = 0, stop bit = 1, each bit held DIV cycles.
- FSM states: IDLE, TX_START, TX_DATA, TX_STOP, RX_WAIT, RX_START, RX_DATA, RX_STOP, DONE.
  - IDLE: start=1 → capture cmd, busy=1, go to TX_START on the next cycle. start is ignored whenever busy=1.
  - TX_START / TX_DATA / TX_STOP: tx=0 for DIV cycles, then cmd[0]..cmd[7] for DIV cycles each, then tx=1 for DIV cycles. Then go to RX_WAIT with byte index=0 and the timeout counter cleared.
  - RX_WAIT: on synchronised rx=0 → RX_START. Otherwise the timeout counter increments. When it reaches TIMEOUT → pulse timeout_err, busy=0, IDLE; result unchanged.
  - RX_START: re-sample at DIV/2. If rx=1 (glitch) → back to RX_WAIT, timeout counter not cleared. If rx=0 → RX_DATA.
  - RX_DATA: sample every DIV cycles from the start-bit midpoint; shift in 8 bits LSB first.
  - RX_STOP: sample after DIV more cycles.
    - rx=0 → pulse framing_err, busy=0, IDLE; partial bytes discarded, result unchanged.
    - rx=1 → store the byte: index 0 → bits [7:0], index 1 → [15:8], index 2 → [23:16] of a shadow register. Increment index. Index<3 → RX_WAIT with timeout counter cleared. Index=3 → DONE.
  - DONE: result ← shadow (all 24 bits in the same cycle), result_valid=1 for one cycle, busy=0, IDLE. A new start is accepted on the following cycle.
- result is never partially updated.
- A sensor byte arriving while in IDLE is ignored.
- result_valid, timeout_err and framing_err are mutually exclusive.
- Reset asserted mid-frame aborts immediately to the reset values above; tx returns high the next cycle.

Test Plan:
1. Command waveform: reset, then start with cmd=0x01, DIV=10. tx low for cycles 1–10 after acceptance; bit0=1, bits1–7=0 in 10-cycle slots; stop high. busy=1 throughout.
2. Normal response: sensor model sends 0x56, 0x34, 0x12 (8N1, 10 cycles/bit) after the command. result=0x123456 with a single-cycle result_valid; busy falls the same cycle; no error pulses.
3. Timeout: send cmd=0x02, no response. timeout_err pulses exactly TIMEOUT cycles after the command stop bit ends; result stays at its previous value (0x123456); busy=0.
4. Framing error: second response byte has stop bit=0. framing_err pulses, result_valid never fires, result unchanged. A following good exchange of 0xAA, 0xBB, 0xCC yields 0xCCBBAA.
5. Robustness: 2-cycle low glitch on rx in RX_WAIT is rejected and the frame still decodes correctly. start pulsed while busy is ignored (only one command seen on tx).
6. Reset mid-reception: rst_n=0 during the second response byte. Next cycle tx=1, busy=0, result=0. A subsequent full exchange works normally.

Source files
------------

// File: rtl/sensor_link_host.sv
// sensor_link_host: host end of the temperature-sensor UART link.
// Sends one command byte, then collects and reassembles a 3-byte average.
module sensor_link_host #(
    parameter int CLK_FREQ = 10000,
    parameter int BAUD     = 1000,
    parameter int TIMEOUT  = 400
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic        rx,
    output logic        tx,
    output logic        busy,
    output logic [23:0] result,
    output logic        result_valid,
    output logic        timeout_err,
    output logic        framing_err
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] MID_LAST = CW'(DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        RX_WAIT,
        RX_START,
        RX_DATA,
        RX_STOP,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    shift_q, shift_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [23:0]   result_q, result_d;
    logic          tmo_err_q, tmo_err_d;
    logic          frm_err_q, frm_err_d;
    logic          rx_s1_q, rx_s2_q;
    logic          rx_s;
    logic          bit_end;

    assign rx_s    = rx_s2_q;
    assign bit_end = (baud_q == BIT_LAST);

    // Two-flop synchroniser for the asynchronous serial input; idles high.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, shift/shadow registers, result and error pulse flops.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            baud_q    <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            cmd_q     <= '0;
            shift_q   <= '0;
            shadow_q  <= '0;
            result_q  <= '0;
            tmo_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            cmd_q     <= cmd_d;
            shift_q   <= shift_d;
            shadow_q  <= shadow_d;
            result_q  <= result_d;
            tmo_err_q <= tmo_err_d;
            frm_err_q <= frm_err_d;
        end
    end

    // Next-state and datapath update; result loads whole on the third good byte.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        cmd_d     = cmd_q;
        shift_d   = shift_q;
        shadow_d  = shadow_q;
        result_d  = result_q;
        tmo_err_d = 1'b0;
        frm_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = TX_START;
                    cmd_d   = cmd;
                    baud_d  = '0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_d = RX_WAIT;
                    baud_d  = '0;
                    idx_d   = '0;
                    tmo_d   = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_WAIT: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    baud_d  = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = IDLE;
                    tmo_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RX_START: begin
                if (baud_q == MID_LAST) begin
                    baud_d = '0;
                    if (rx_s) begin
                        state_d = RX_WAIT;
                    end else begin
                        state_d = RX_DATA;
                        bit_d   = '0;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (!rx_s) begin
                        state_d   = IDLE;
                        frm_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        tmo_d = '0;
                        if (idx_q == 2'd2) begin
                            state_d  = DONE;
                            result_d = {shift_q, shadow_q};
                        end else begin
                            state_d = RX_WAIT;
                            if (idx_q[0]) begin
                                shadow_d[15:8] = shift_q;
                            end else begin
                                shadow_d[7:0] = shift_q;
                            end
                        end
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        tx           = 1'b1;
        busy         = 1'b1;
        result_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            TX_START: begin
                tx = 1'b0;
            end
            TX_DATA: begin
                tx = cmd_q[bit_q];
            end
            DONE: begin
                busy         = 1'b0;
                result_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign result      = result_q;
    assign timeout_err = tmo_err_q;
    assign framing_err = frm_err_q;

endmodule

// File: tb/tb_sensor_link_host.sv
// tb_sensor_link_host: directed bench with a cycle-level model of the link.
// The sensor side is emulated by a byte sender driving rx.
module tb_sensor_link_host;

    localparam int DIV = 10;
    localparam int TMO = 400;
    // start-bit edge to pulse: 2 sync flops, half a bit to the start
    // midpoint, 9 bits to the stop midpoint, one cycle to register it
    localparam int RESP_LAT = 3 + DIV / 2 + 9 * DIV;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic        rx = 1'b1;
    logic        tx;
    logic        busy;
    logic [23:0] result;
    logic        result_valid;
    logic        timeout_err;
    logic        framing_err;

    sensor_link_host #(
        .CLK_FREQ(10000),
        .BAUD    (1000),
        .TIMEOUT (TMO)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .start       (start),
        .cmd         (cmd),
        .rx          (rx),
        .tx          (tx),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid),
        .timeout_err (timeout_err),
        .framing_err (framing_err)
    );

    always #5 clk1 = ~clk1;

    int   cyc = 0;
    logic rst_seen = 1'b0;

    always @(posedge clk1) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_n;
    end

    int checks = 0;
    int failures = 0;

    // model of the expected link behaviour
    int          tx_s = -1000;
    logic [7:0]  tx_cmd = 8'h00;
    int          busy_lo = -1;
    int          busy_hi = -1;
    int          ev_cyc = -1;
    int          ev_kind = 0;
    logic [23:0] ev_val = 24'h0;
    logic [23:0] exp_result = 24'h0;
    int          tmo_seen = -1;
    int          rv_count = 0;
    int          te_count = 0;
    int          fe_count = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk1) begin : cmp
        int   k;
        logic etx;
        if (cyc >= 1) begin
            if (!rst_seen) begin
                tx_s       = -1000;
                busy_lo    = -1;
                busy_hi    = -1;
                ev_kind    = 0;
                exp_result = 24'h0;
                chk("rst_tx", tx, 1);
                chk("rst_busy", busy, 0);
                chk("rst_result", result, 0);
                chk("rst_rv", result_valid, 0);
                chk("rst_te", timeout_err, 0);
                chk("rst_fe", framing_err, 0);
            end else begin
                k   = cyc - tx_s;
                etx = 1'b1;
                if (k >= 1 && k <= DIV) begin
                    etx = 1'b0;
                end else if (k > DIV && k <= 9 * DIV) begin
                    etx = tx_cmd[(k - DIV - 1) / DIV];
                end
                if (cyc == ev_cyc && ev_kind == 1) begin
                    exp_result = ev_val;
                end
                chk("tx", tx, etx);
                chk("busy", busy, (cyc >= busy_lo && cyc < busy_hi));
                chk("result", result, exp_result);
                chk("result_valid", result_valid,
                    (cyc == ev_cyc && ev_kind == 1));
                chk("timeout_err", timeout_err,
                    (cyc == ev_cyc && ev_kind == 2));
                chk("framing_err", framing_err,
                    (cyc == ev_cyc && ev_kind == 3));
            end
            if (result_valid === 1'b1) rv_count++;
            if (framing_err === 1'b1) fe_count++;
            if (timeout_err === 1'b1) begin
                te_count++;
                tmo_seen = cyc;
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk1);
    endtask

    task automatic issue(input logic [7:0] c, input bit expect_tmo,
                         output int s);
        s       = cyc;
        cmd     = c;
        start   = 1'b1;
        tx_s    = s;
        tx_cmd  = c;
        busy_lo = s + 1;
        busy_hi = 1 << 30;
        if (expect_tmo) begin
            ev_cyc  = s + 1 + 10 * DIV + TMO;
            ev_kind = 2;
            busy_hi = ev_cyc;
        end
        @(negedge clk1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok,
                             input int kind, input logic [23:0] val);
        int a;
        a = cyc;
        if (kind != 0) begin
            ev_cyc  = a + RESP_LAT;
            ev_kind = kind;
            ev_val  = val;
            busy_hi = a + RESP_LAT;
        end
        rx = 1'b0;
        repeat (DIV) @(negedge clk1);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk1);
        end
        rx = stop_ok;
        repeat (DIV) @(negedge clk1);
        rx = 1'b1;
    endtask

    initial begin
        int s;
        rst_n = 1'b0;
        repeat (4) @(negedge clk1);
        chk("init_tx", tx, 1);
        chk("init_busy", busy, 0);
        chk("init_result", result, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk1);

        // command waveform and normal response
        issue(8'h01, 1'b0, s);
        wait_until(s + 5);
        chk("cmd_start_low", tx, 0);
        wait_until(s + 15);
        chk("cmd_bit0", tx, 1);
        wait_until(s + 25);
        chk("cmd_bit1", tx, 0);
        wait_until(s + 95);
        chk("cmd_stop", tx, 1);
        chk("cmd_busy", busy, 1);
        wait_until(s + 104);
        send_byte(8'h56, 1'b1, 0, 24'h0);
        send_byte(8'h34, 1'b1, 0, 24'h0);
        send_byte(8'h12, 1'b1, 1, 24'h123456);
        chk("normal_result", result, 24'h123456);
        chk("normal_rv_count", rv_count, 1);
        chk("normal_busy", busy, 0);

        // timeout with no response
        repeat (3) @(negedge clk1);
        issue(8'h02, 1'b1, s);
        wait_until(s + 510);
        chk("tmo_latency", tmo_seen - (s + 101), 400);
        chk("tmo_count", te_count, 1);
        chk("tmo_result", result, 24'h123456);
        chk("tmo_busy", busy, 0);

        // framing error on the second byte, then a good exchange
        issue(8'h03, 1'b0, s);
        wait_until(s + 104);
        send_byte(8'h11, 1'b1, 0, 24'h0);
        send_byte(8'h22, 1'b0, 3, 24'h0);
        repeat (5) @(negedge clk1);
        chk("frm_count", fe_count, 1);
        chk("frm_rv_count", rv_count, 1);
        chk("frm_result", result, 24'h123456);
        issue(8'h33, 1'b0, s);
        wait_until(s + 104);
        send_byte(8'hAA, 1'b1, 0, 24'h0);
        send_byte(8'hBB, 1'b1, 0, 24'h0);
        send_byte(8'hCC, 1'b1, 1, 24'hCCBBAA);
        chk("good_result", result, 24'hCCBBAA);
        chk("good_rv_count", rv_count, 2);

        // start while busy is ignored; rx glitch is rejected
        repeat (3) @(negedge clk1);
        issue(8'h5A, 1'b0, s);
        wait_until(s + 30);
        cmd   = 8'hFF;
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        wait_until(s + 35);
        chk("busy_start_ignored", tx, 0);
        wait_until(s + 105);
        rx = 1'b0;
        repeat (2) @(negedge clk1);
        rx = 1'b1;
        repeat (12) @(negedge clk1);
        send_byte(8'h01, 1'b1, 0, 24'h0);
        send_byte(8'h02, 1'b1, 0, 24'h0);
        send_byte(8'h03, 1'b1, 1, 24'h030201);
        chk("glitch_result", result, 24'h030201);
        chk("glitch_errs", te_count + fe_count, 2);

        // reset in the middle of the second response byte
        repeat (3) @(negedge clk1);
        issue(8'h06, 1'b0, s);
        wait_until(s + 104);
        send_byte(8'h10, 1'b1, 0, 24'h0);
        rx = 1'b0;
        repeat (DIV) @(negedge clk1);
        rx = 1'b1;
        repeat (DIV) @(negedge clk1);
        rx = 1'b0;
        repeat (5) @(negedge clk1);
        rst_n = 1'b0;
        @(negedge clk1);
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk1);

        // byte arriving while idle is ignored
        send_byte(8'h77, 1'b1, 0, 24'h0);
        repeat (5) @(negedge clk1);
        chk("idle_byte_result", result, 0);
        chk("idle_byte_rv", rv_count, 3);

        issue(8'h07, 1'b0, s);
        wait_until(s + 104);
        send_byte(8'hDE, 1'b1, 0, 24'h0);
        send_byte(8'hAD, 1'b1, 0, 24'h0);
        send_byte(8'hBE, 1'b1, 1, 24'hBEADDE);
        chk("post_rst_result", result, 24'hBEADDE);
        chk("post_rst_rv", rv_count, 4);
        repeat (3) @(negedge clk1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
